// File: rtl/game_pkg.sv
// Shared types for the player action arbiter: directions, action kinds,
// arbiter states and the action payload.
package game_pkg;

    localparam int unsigned DIR_W  = 2;
    localparam int unsigned MOVE_W = 4;

    typedef enum logic [DIR_W-1:0] {
        DIR_LEFT  = 2'd0,
        DIR_UP    = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic {
        ACT_MOVE = 1'b0,
        ACT_BOMB = 1'b1
    } act_kind_e;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OFFER = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic      player;
        act_kind_e kind;
        dir_e      dir;
    } action_t;

    // Lowest set bit wins: left > up > down > right.
    function automatic dir_e first_dir(input logic [MOVE_W-1:0] move);
        dir_e d;
        if (move[0])      d = DIR_LEFT;
        else if (move[1]) d = DIR_UP;
        else if (move[2]) d = DIR_DOWN;
        else              d = DIR_RIGHT;
        return d;
    endfunction

endpackage

// File: rtl/player_action_arbiter_if.sv
// Board-update action port: valid/ready handshake carrying one game action.
interface player_action_arbiter_if;
    import game_pkg::*;

    logic      act_valid;
    logic      act_ready;
    logic      act_player;
    act_kind_e act_kind;
    dir_e      act_dir;

    modport master (
        output act_valid,
        output act_player,
        output act_kind,
        output act_dir,
        input  act_ready
    );

    modport slave (
        input  act_valid,
        input  act_player,
        input  act_kind,
        input  act_dir,
        output act_ready
    );
endinterface

// File: rtl/player_req_gen.sv
// Per-player request generator: bomb edge detect + sticky pending flag,
// move cooldown and direction encode. Optional BOMB_LIMIT_EN live-bomb cap.
module player_req_gen
    import game_pkg::*;
#(
    parameter int unsigned MOVE_PERIOD = 8,
    parameter int unsigned CD_W        = 4
`ifdef BOMB_LIMIT_EN
    ,
    parameter int unsigned MAX_BOMBS   = 3
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              frame_tick,
    input  logic [MOVE_W-1:0] move,
    input  logic              bomb,
`ifdef BOMB_LIMIT_EN
    input  logic              bomb_done,
`endif
    input  logic              grant,
    input  act_kind_e         grant_kind,
    output logic              req,
    output act_kind_e         req_kind,
    output dir_e              req_dir
);

    logic            bomb_q;
    logic            bomb_pend;
    logic [CD_W-1:0] cooldown;
    logic            bomb_req;
    logic            move_req;
    logic            grant_bomb;
    logic            grant_move;

    assign grant_bomb = grant && (grant_kind == ACT_BOMB);
    assign grant_move = grant && (grant_kind == ACT_MOVE);

    // Edge detect always tracks the key so a bomb held across enable does not fire.
    always_ff @(posedge clk) begin
        if (reset) begin
            bomb_q    <= 1'b0;
            bomb_pend <= 1'b0;
            cooldown  <= '0;
        end else begin
            bomb_q <= bomb;
            if (!enable) begin
                bomb_pend <= 1'b0;
                cooldown  <= '0;
            end else begin
                if (bomb && !bomb_q)
                    bomb_pend <= 1'b1;
                else if (grant_bomb)
                    bomb_pend <= 1'b0;

                if (grant_move)
                    cooldown <= CD_W'(MOVE_PERIOD);
                else if (frame_tick && (cooldown != '0))
                    cooldown <= cooldown - CD_W'(1);
            end
        end
    end

`ifdef BOMB_LIMIT_EN
    localparam int unsigned BC_W = $clog2(MAX_BOMBS + 1);

    logic [BC_W-1:0] live_bombs;

    // Grant and explosion in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            live_bombs <= '0;
        end else if (grant_bomb && !bomb_done) begin
            live_bombs <= live_bombs + BC_W'(1);
        end else if (bomb_done && !grant_bomb && (live_bombs != '0)) begin
            live_bombs <= live_bombs - BC_W'(1);
        end
    end

    assign bomb_req = bomb_pend && (live_bombs != BC_W'(MAX_BOMBS));
`else
    assign bomb_req = bomb_pend;
`endif

    assign move_req = (|move) && (cooldown == '0);
    assign req      = bomb_req || move_req;
    assign req_kind = bomb_req ? ACT_BOMB : ACT_MOVE;
    assign req_dir  = bomb_req ? DIR_LEFT : first_dir(move);

endmodule

// File: rtl/player_action_arbiter.sv
// Round-robin arbiter turning two players' held controls into rate-limited
// board actions on one valid/ready port. Optional: BOMB_LIMIT_EN.
module player_action_arbiter
    import game_pkg::*;
#(
    parameter int unsigned MOVE_PERIOD = 8,
    parameter int unsigned CD_W        = 4
`ifdef BOMB_LIMIT_EN
    ,
    parameter int unsigned MAX_BOMBS   = 3
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    frame_tick,
    input  logic [MOVE_W-1:0]       p1_move,
    input  logic [MOVE_W-1:0]       p2_move,
    input  logic                    p1_bomb,
    input  logic                    p2_bomb,
`ifdef BOMB_LIMIT_EN
    input  logic                    p1_bomb_done,
    input  logic                    p2_bomb_done,
`endif
    player_action_arbiter_if.master act
);

    arb_state_e state;
    arb_state_e state_d;
    action_t    act_q;
    action_t    act_d;
    logic       rr_q;
    logic       rr_d;
    logic       grant_fire;
    logic       win;
    logic [1:0] req;
    act_kind_e  req_kind [2];
    dir_e       req_dir  [2];

    player_req_gen #(
        .MOVE_PERIOD (MOVE_PERIOD),
        .CD_W        (CD_W)
`ifdef BOMB_LIMIT_EN
        ,
        .MAX_BOMBS   (MAX_BOMBS)
`endif
    ) u_p1 (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .frame_tick (frame_tick),
        .move       (p1_move),
        .bomb       (p1_bomb),
`ifdef BOMB_LIMIT_EN
        .bomb_done  (p1_bomb_done),
`endif
        .grant      (grant_fire && !act_q.player),
        .grant_kind (act_q.kind),
        .req        (req[0]),
        .req_kind   (req_kind[0]),
        .req_dir    (req_dir[0])
    );

    player_req_gen #(
        .MOVE_PERIOD (MOVE_PERIOD),
        .CD_W        (CD_W)
`ifdef BOMB_LIMIT_EN
        ,
        .MAX_BOMBS   (MAX_BOMBS)
`endif
    ) u_p2 (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .frame_tick (frame_tick),
        .move       (p2_move),
        .bomb       (p2_bomb),
`ifdef BOMB_LIMIT_EN
        .bomb_done  (p2_bomb_done),
`endif
        .grant      (grant_fire && act_q.player),
        .grant_kind (act_q.kind),
        .req        (req[1]),
        .req_kind   (req_kind[1]),
        .req_dir    (req_dir[1])
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ARB_IDLE;
        else       state <= state_d;
    end

    // Next state: enable low aborts any offer.
    always_comb begin
        state_d = state;
        case (state)
            ARB_IDLE:  if (enable && (|req)) state_d = ARB_OFFER;
            ARB_OFFER: if (!enable || act.act_ready) state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    // Outputs: winner snapshot in IDLE, grant and RR flip on handshake.
    always_comb begin
        act_d      = act_q;
        rr_d       = rr_q;
        grant_fire = 1'b0;
        win        = (req[0] && req[1]) ? rr_q : req[1];
        case (state)
            ARB_IDLE: begin
                if (enable && (|req))
                    act_d = '{player: win, kind: req_kind[win], dir: req_dir[win]};
            end
            ARB_OFFER: begin
                if (enable && act.act_ready) begin
                    grant_fire = 1'b1;
                    rr_d       = ~act_q.player;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act_q <= '0;
            rr_q  <= 1'b0;
        end else begin
            act_q <= act_d;
            rr_q  <= rr_d;
        end
    end

    assign act.act_valid  = (state == ARB_OFFER);
    assign act.act_player = act_q.player;
    assign act.act_kind   = act_q.kind;
    assign act.act_dir    = act_q.dir;

endmodule

// File: tb/tb_player_action_arbiter.sv
// Bench for player_action_arbiter: directed scenarios plus random traffic
// against a rule-level reference model. Honours BOMB_LIMIT_EN.
module tb_player_action_arbiter;
    import game_pkg::*;

    localparam int MOVE_PERIOD = 8;
    localparam int MAX_BOMBS   = 3;
    localparam int BIG         = 1000;

    logic       clk = 1'b0;
    logic       reset, enable, frame_tick;
    logic [3:0] p1_move, p2_move;
    logic       p1_bomb, p2_bomb;
`ifdef BOMB_LIMIT_EN
    logic       p1_bomb_done, p2_bomb_done;
`endif

    always #5 clk = ~clk;

    player_action_arbiter_if act_if ();

    player_action_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .frame_tick   (frame_tick),
        .p1_move      (p1_move),
        .p2_move      (p2_move),
        .p1_bomb      (p1_bomb),
        .p2_bomb      (p2_bomb),
`ifdef BOMB_LIMIT_EN
        .p1_bomb_done (p1_bomb_done),
        .p2_bomb_done (p2_bomb_done),
`endif
        .act          (act_if.master)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: pending offer, sticky bombs, frame ticks since last move grant.
    bit       m_valid, m_player, m_kind, m_rr;
    bit [1:0] m_dir;
    bit       m_prev [2];
    bit       m_pend [2];
    int       m_since[2];
    int       m_live [2];

    typedef struct {
        int player;
        int kind;
        int dir;
        int cyc;
        int tick;
    } grant_rec_t;
    grant_rec_t glog[$];
    int cyc    = 0;
    int nticks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit [3:0] mv(input int p);
        return (p == 0) ? p1_move : p2_move;
    endfunction

    function automatic bit bb(input int p);
        return (p == 0) ? p1_bomb : p2_bomb;
    endfunction

    function automatic bit bdone(input int p);
`ifdef BOMB_LIMIT_EN
        return (p == 0) ? p1_bomb_done : p2_bomb_done;
`else
        return (p < 0);
`endif
    endfunction

    task automatic model_reset();
        m_valid = 0; m_player = 0; m_kind = 0; m_dir = 0; m_rr = 0;
        for (int p = 0; p < 2; p++) begin
            m_prev[p] = 0; m_pend[p] = 0; m_since[p] = BIG; m_live[p] = 0;
        end
    endtask

    task automatic model_step();
        bit       req [2];
        bit       rk  [2];
        bit [1:0] rd  [2];
        bit       rise[2];
        bit       grant, gp, gk, bok, inc, dec;
        int       w;
        if (reset) begin
            model_reset();
            return;
        end
        for (int p = 0; p < 2; p++) begin
            bok = m_pend[p];
`ifdef BOMB_LIMIT_EN
            bok = bok && (m_live[p] < MAX_BOMBS);
`endif
            req[p] = bok || ((mv(p) != 0) && (m_since[p] >= MOVE_PERIOD));
            rk[p]  = bok;
            rd[p]  = 0;
            if (!bok)
                for (int i = 3; i >= 0; i--) if (mv(p)[i]) rd[p] = 2'(i);
            rise[p]   = bb(p) && !m_prev[p];
            m_prev[p] = bb(p);
        end
        grant = m_valid && act_if.act_ready && enable;
        gp = m_player;
        gk = m_kind;
        if (!enable) begin
            m_valid = 0;
            for (int p = 0; p < 2; p++) begin
                m_pend[p] = 0; m_since[p] = BIG; m_live[p] = 0;
            end
            return;
        end
        if (m_valid) begin
            if (act_if.act_ready) begin
                m_valid = 0;
                m_rr    = !gp;
            end
        end else if (req[0] || req[1]) begin
            w        = (req[0] && req[1]) ? int'(m_rr) : (req[1] ? 1 : 0);
            m_valid  = 1;
            m_player = w[0];
            m_kind   = rk[w];
            m_dir    = rd[w];
        end
        for (int p = 0; p < 2; p++) begin
            if (rise[p])                                m_pend[p] = 1;
            else if (grant && (gp == p[0]) && gk)       m_pend[p] = 0;
            if (grant && (gp == p[0]) && !gk)           m_since[p] = 0;
            else if (frame_tick && (m_since[p] < BIG))  m_since[p]++;
            inc = grant && (gp == p[0]) && gk;
            dec = bdone(p);
            if (inc && !dec)                            m_live[p]++;
            else if (dec && !inc && (m_live[p] > 0))    m_live[p]--;
        end
    endtask

    // One clock: log an observed handshake, advance model, compare after the edge.
    task automatic tick();
        if (act_if.act_valid && act_if.act_ready && enable && !reset)
            glog.push_back('{int'(act_if.act_player), int'(act_if.act_kind),
                             int'(act_if.act_dir), cyc, nticks});
        @(posedge clk);
        model_step();
        if (frame_tick) nticks++;
        cyc++;
        #1;
        check("act_valid", act_if.act_valid, m_valid);
        if (m_valid) begin
            check("act_player", act_if.act_player, m_player);
            check("act_kind",   act_if.act_kind,   m_kind);
            check("act_dir",    act_if.act_dir,    m_dir);
        end
    endtask

    task automatic idle_inputs();
        enable = 0; frame_tick = 0; p1_move = 0; p2_move = 0;
        p1_bomb = 0; p2_bomb = 0; act_if.act_ready = 0;
`ifdef BOMB_LIMIT_EN
        p1_bomb_done = 0; p2_bomb_done = 0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int k = 0;
        while (!act_if.act_valid && k < budget) begin
            tick();
            k++;
        end
        check(tag, act_if.act_valid, 1);
    endtask

    initial begin
        model_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        check("reset valid",  act_if.act_valid,  0);
        check("reset player", act_if.act_player, 0);
        check("reset kind",   act_if.act_kind,   0);
        check("reset dir",    act_if.act_dir,    0);
        reset = 0;

        // Held down-move: grants spaced by MOVE_PERIOD frame ticks.
        enable = 1; act_if.act_ready = 1; p1_move = 4'b0100;
        glog.delete(); nticks = 0;
        for (int k = 0; nticks < 20; k++) begin
            frame_tick = ((k % 4) == 3);
            tick();
        end
        frame_tick = 0;
        tick(); tick();
        p1_move = 0;
        tick(); tick();
        check("move grants", glog.size(), 3);
        if (glog.size() == 3) begin
            check("move first tick", glog[0].tick, 0);
            for (int i = 0; i < 3; i++) begin
                check("move player", glog[i].player, 0);
                check("move kind",   glog[i].kind,   0);
                check("move dir",    glog[i].dir,    2);
                if (i > 0) check("move spacing", glog[i].tick - glog[i-1].tick, MOVE_PERIOD);
            end
        end

        // Simultaneous bombs, twice: p1 first both times.
        do_reset();
        enable = 1; act_if.act_ready = 1; glog.delete();
        for (int r = 0; r < 2; r++) begin
            p1_bomb = 1; p2_bomb = 1;
            repeat (8) tick();
            p1_bomb = 0; p2_bomb = 0;
            repeat (2) tick();
        end
        check("bomb grants", glog.size(), 4);
        if (glog.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("bomb order", glog[i].player, i % 2);
                check("bomb kind",  glog[i].kind,   1);
                check("bomb dir",   glog[i].dir,    0);
            end
            check("bomb gap a", glog[1].cyc - glog[0].cyc, 2);
            check("bomb gap b", glog[3].cyc - glog[2].cyc, 2);
        end

        // Stalled offer stays stable; one grant on ready.
        do_reset();
        enable = 1; p2_move = 4'b1001;
        wait_valid(4, "p2 offer");
        for (int i = 0; i < 5; i++) begin
            check("stall valid",  act_if.act_valid,  1);
            check("stall player", act_if.act_player, 1);
            check("stall dir",    act_if.act_dir,    0);
            tick();
        end
        glog.delete();
        act_if.act_ready = 1;
        repeat (6) tick();
        check("stall grants", glog.size(), 1);
        p2_move = 0;
        tick();

        // Held bomb key: exactly one bomb until re-press.
        do_reset();
        enable = 1; act_if.act_ready = 1; glog.delete();
        p1_bomb = 1;
        repeat (50) tick();
        check("held bomb grants", glog.size(), 1);
        p1_bomb = 0;
        tick(); tick();
        p1_bomb = 1;
        repeat (6) tick();
        check("repress bomb grants", glog.size(), 2);
        p1_bomb = 0;
        tick();

        // Enable drop mid-offer aborts; no stale bomb after return.
        do_reset();
        enable = 1; p1_bomb = 1;
        wait_valid(4, "abort offer");
        check("abort offer kind", act_if.act_kind, 1);
        enable = 0;
        tick();
        check("abort valid", act_if.act_valid, 0);
        p1_move = 4'b0010; enable = 1; glog.delete();
        wait_valid(3, "move after enable");
        check("reenable kind", act_if.act_kind, 0);
        check("reenable dir",  act_if.act_dir,  1);
        act_if.act_ready = 1;
        repeat (12) tick();
        check("reenable grants", glog.size(), 1);
        p1_move = 0; p1_bomb = 0;
        tick();

`ifdef BOMB_LIMIT_EN
        // Live-bomb cap: 4th press waits for an explosion.
        do_reset();
        enable = 1; act_if.act_ready = 1; glog.delete();
        for (int i = 0; i < 4; i++) begin
            p1_bomb = 1;
            repeat (3) tick();
            p1_bomb = 0;
            repeat (3) tick();
        end
        check("capped grants", glog.size(), 3);
        p1_bomb_done = 1;
        tick();
        p1_bomb_done = 0;
        tick(); tick();
        check("after done grants", glog.size(), 4);
`endif

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 199) == 0);
            enable     = ($urandom_range(0, 19) != 0);
            frame_tick = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) p1_move = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) p2_move = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) p1_bomb = ~p1_bomb;
            if ($urandom_range(0, 5) == 0) p2_bomb = ~p2_bomb;
            act_if.act_ready = ($urandom_range(0, 2) != 0);
`ifdef BOMB_LIMIT_EN
            p1_bomb_done = ($urandom_range(0, 9) == 0);
            p2_bomb_done = ($urandom_range(0, 9) == 0);
`endif
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/player_action_arbiter.md
Name: player_action_arbiter

Overview:
- Converts the level-held per-player controls (move one-hots, bomb levels) into discrete, rate-limited game actions.
- Arbitrates those actions between player 1 and player 2 onto the single board-update port using round-robin and a valid/ready handshake.
- Sits between the keyboard-decoded player controls and the game-state/board logic.

Parameters:
- MOVE_PERIOD, 8: frame_ticks between successive granted moves of one player while a direction is held.
- CD_W, 4: cooldown counter width; requires MOVE_PERIOD < 2**CD_W.
- MAX_BOMBS, 3: outstanding bombs per player; only used with BOMB_LIMIT_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  game running; low = suppress and flush all actions
- frame_tick  in  1  one-cycle pulse per video frame
- p1_move  in  4  held directions: [0] left, [1] up, [2] down, [3] right
- p2_move  in  4  same encoding as p1_move
- p1_bomb  in  1  bomb key level
- p2_bomb  in  1  bomb key level
- act_ready  in  1  board port accepts action
- act_valid  out  1  action offered
- act_player  out  1  0 = p1, 1 = p2
- act_kind  out  1  0 = move, 1 = bomb
- act_dir  out  2  0 left, 1 up, 2 down, 3 right; 0 when act_kind = bomb
- p1_bomb_done / p2_bomb_done  in  1  bomb exploded pulse (BOMB_LIMIT_EN only)

Behaviour:
- Reset: act_valid = 0, act_player = 0, act_kind = 0, act_dir = 0; both cooldowns = 0; pending bomb flags = 0; round-robin pointer favours p1; bomb edge-detect registers = 0.
- Per-player request generation:
  - Bomb: a rising edge of the bomb level sets a sticky bomb_pend flag. The flag clears on grant of that player's bomb. A held key produces exactly one bomb.
  - Move: move_req = |move && cooldown == 0. Direction = lowest set bit index, so multiple keys resolve to priority left > up > down > right.
  - Within one player, a bomb request outranks a move request.
  - Cooldown: loaded with MOVE_PERIOD on a move grant. Decrements by 1 on frame_tick when nonzero. Saturates at 0. A load in the same cycle as frame_tick wins over the decrement.
- Arbiter FSM, 2 states:
  - IDLE: if enable and any request exists, pick the winner and register the act_* fields. If both players request, the player indicated by the RR pointer wins. Go to OFFER with act_valid = 1 on the next cycle (1-cycle latency from request to valid).
  - OFFER: act_* fields are held stable while act_ready = 0.
  - On act_valid && act_ready:
    - Grant: clear that player's bomb_pend, or load its cooldown.
    - Flip the RR pointer to the other player.
    - Return to IDLE with act_valid = 0 for at least one cycle.
  - Sustained throughput is therefore one action per 2 cycles.
- The offered action is a snapshot. A key released during OFFER does not withdraw or alter it.
- enable low:
  - Forces IDLE and act_valid = 0 on the next cycle. This abort is the only permitted handshake withdrawal.
  - Clears both bomb_pend flags and zeroes both cooldowns.
  - Edge-detect registers keep tracking, so a bomb held across an enable rise does not fire.
- Reset mid-OFFER returns all state to reset values on the next edge; the action is lost.

Optional Feature:
- BOMB_LIMIT_EN defined:
  - Per-player live-bomb counter, width clog2(MAX_BOMBS+1).
  - Incremented on bomb grant; decremented on the matching *_bomb_done pulse. Both in one cycle leaves the counter unchanged.
  - A bomb request is masked while counter == MAX_BOMBS. bomb_pend stays set, so the bomb fires once the counter drops.
  - Decrement saturates at 0. Counters are zeroed by reset and by enable low.
- BOMB_LIMIT_EN undefined: the *_bomb_done ports and counters do not exist; bombs are unlimited.

Decomposition:
- Package game_pkg:
  - dir_e (DIR_LEFT=0, DIR_UP, DIR_DOWN, DIR_RIGHT)
  - act_kind_e (ACT_MOVE, ACT_BOMB)
  - arb_state_e (ARB_IDLE, ARB_OFFER)
  - struct action_t {player, kind, dir}
- Sub-module player_req_gen, instantiated twice. It contains edge detect, bomb_pend, cooldown, optional bomb counter, and direction encode. It outputs req, req_kind, req_dir and takes a grant pulse.

Test Plan:
- Hold p1_move = 4'b0100 with act_ready = 1 for 20 frame_ticks -> move grants with act_dir = 2, spaced exactly 8 frame_ticks apart: 3 grants (first immediate, then after ticks 8 and 16).
- p1_bomb and p2_bomb rise in the same cycle -> offers p1 bomb then p2 bomb, 2 cycles apart. Repeat the same event -> order is still p1 first, since RR pointer is back on p1 after two grants.
- p2_move = 4'b1001 held, act_ready low for 5 cycles after valid -> act_valid, act_player = 1, act_dir = 0 stable for all 5 cycles; exactly one grant when ready rises.
- p1 holds bomb for 50 cycles -> exactly one bomb action; no further bomb until release and re-press.
- enable dropped during OFFER -> act_valid = 0 next cycle; after enable returns, no stale bomb is offered and a held direction moves immediately (cooldown 0).
- With BOMB_LIMIT_EN: 4 bomb presses by p1 -> 3 grants; one p1_bomb_done pulse -> 4th grant follows within 2 cycles.
